ysyx_23060332_mem_arbiter: RTL and testbench

Sequencing arbiter sharing the single combinational-read / clocked-write data memory port between the instruction fetch unit (IFU) and the load/store unit (LSU). Accepts one request at a time over a valid/ready handshake, holds the memory port for a programmable number of access cycles, then returns a registered one-cycle response to the granted requester. Sits between the IFU/LSU and the memory block; it is the only driver of the memory port.

---
 rtl/ysyx_23060332_mem_arbiter_if.sv | 44 ++++
 rtl/ysyx_23060332_mem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_ysyx_23060332_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060332_mem_arbiter_if.sv
// Bus bundle between the IFU/LSU requesters, the shared data-memory port and the arbiter.
// The arbiter connects through the slave modport; the environment connects through master.
interface ysyx_23060332_mem_arbiter_if;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_req_addr;
    logic        ifu_resp_valid;
    logic [31:0] ifu_resp_rdata;

    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [31:0] lsu_req_addr;
    logic        lsu_req_wen;
    logic [31:0] lsu_req_wdata;
    logic [7:0]  lsu_req_wmask;
    logic        lsu_resp_valid;
    logic [31:0] lsu_resp_rdata;

    logic        mem_ren;
    logic [31:0] mem_raddr;
    logic        mem_wen;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic [31:0] mem_rdata;

    modport slave (
        input  ifu_req_valid, ifu_req_addr,
        input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
        input  mem_rdata,
        output ifu_req_ready, ifu_resp_valid, ifu_resp_rdata,
        output lsu_req_ready, lsu_resp_valid, lsu_resp_rdata,
        output mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_wmask
    );

    modport master (
        output ifu_req_valid, ifu_req_addr,
        output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
        output mem_rdata,
        input  ifu_req_ready, ifu_resp_valid, ifu_resp_rdata,
        input  lsu_req_ready, lsu_resp_valid, lsu_resp_rdata,
        input  mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/ysyx_23060332_mem_arbiter.sv
// IFU/LSU arbiter for the single data-memory port: one transaction at a time, LATENCY access cycles.
// Define YSYX_23060332_ARB_RR_EN for round-robin arbitration; otherwise LSU has fixed priority.
module ysyx_23060332_mem_arbiter #(
    parameter int unsigned LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    ysyx_23060332_mem_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  wmask_q, wmask_d;
    logic        wen_q, wen_d;
    logic        owner_lsu_q, owner_lsu_d;
    logic [31:0] ifu_rdata_q, ifu_rdata_d;
    logic [31:0] lsu_rdata_q, lsu_rdata_d;

    logic        grant_ifu_s, grant_lsu_s;
    logic        ifu_ready_s, lsu_ready_s;
    logic        mem_ren_s, mem_wen_s;
    logic [31:0] mem_addr_s, mem_wdata_s;
    logic [7:0]  mem_wmask_s;

`ifdef YSYX_23060332_ARB_RR_EN
    logic        last_lsu_q, last_lsu_d;

    // Round-robin winner: on conflict the requester not granted last time wins.
    always_comb begin
        grant_ifu_s = 1'b0;
        grant_lsu_s = 1'b0;
        if (bus.ifu_req_valid && bus.lsu_req_valid) begin
            grant_ifu_s = last_lsu_q;
            grant_lsu_s = ~last_lsu_q;
        end else begin
            grant_ifu_s = bus.ifu_req_valid;
            grant_lsu_s = bus.lsu_req_valid;
        end
    end
`else
    // Fixed-priority winner: LSU always beats IFU.
    always_comb begin
        grant_lsu_s = bus.lsu_req_valid;
        grant_ifu_s = bus.ifu_req_valid & ~bus.lsu_req_valid;
    end
`endif

    // Ready only in IDLE; held low during reset so no request is taken that reset would drop.
    assign ifu_ready_s = (state_q == ST_IDLE) & ~rst & grant_ifu_s;
    assign lsu_ready_s = (state_q == ST_IDLE) & ~rst & grant_lsu_s;

    // Next-state, request latching, memory port drive and response capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        wen_d       = wen_q;
        owner_lsu_d = owner_lsu_q;
        ifu_rdata_d = ifu_rdata_q;
        lsu_rdata_d = lsu_rdata_q;
`ifdef YSYX_23060332_ARB_RR_EN
        last_lsu_d  = last_lsu_q;
`endif
        mem_ren_s   = 1'b0;
        mem_wen_s   = 1'b0;
        mem_addr_s  = 32'h0000_0000;
        mem_wdata_s = 32'h0000_0000;
        mem_wmask_s = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (lsu_ready_s) begin
                    owner_lsu_d = 1'b1;
                    addr_d      = bus.lsu_req_addr;
                    wen_d       = bus.lsu_req_wen;
                    wdata_d     = bus.lsu_req_wdata;
                    wmask_d     = bus.lsu_req_wmask;
                    cnt_d       = CNT_LOAD;
                    state_d     = ST_ACCESS;
`ifdef YSYX_23060332_ARB_RR_EN
                    last_lsu_d  = 1'b1;
`endif
                end else if (ifu_ready_s) begin
                    owner_lsu_d = 1'b0;
                    addr_d      = bus.ifu_req_addr;
                    wen_d       = 1'b0;
                    wdata_d     = 32'h0000_0000;
                    wmask_d     = 8'h00;
                    cnt_d       = CNT_LOAD;
                    state_d     = ST_ACCESS;
`ifdef YSYX_23060332_ARB_RR_EN
                    last_lsu_d  = 1'b0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                mem_ren_s   = ~wen_q;
                mem_addr_s  = addr_q;
                mem_wdata_s = wdata_q;
                mem_wmask_s = wmask_q;
                if (cnt_q == 4'd0) begin
                    // Store commits at the edge closing this cycle; an empty mask writes nothing.
                    mem_wen_s = wen_q & (|wmask_q) & ~rst;
                    if (owner_lsu_q) begin
                        lsu_rdata_d = wen_q ? 32'h0000_0000 : bus.mem_rdata;
                    end else begin
                        ifu_rdata_d = bus.mem_rdata;
                    end
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = ST_ACCESS;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= 32'h0000_0000;
            wdata_q     <= 32'h0000_0000;
            wmask_q     <= 8'h00;
            wen_q       <= 1'b0;
            owner_lsu_q <= 1'b0;
            ifu_rdata_q <= 32'h0000_0000;
            lsu_rdata_q <= 32'h0000_0000;
`ifdef YSYX_23060332_ARB_RR_EN
            last_lsu_q  <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            wen_q       <= wen_d;
            owner_lsu_q <= owner_lsu_d;
            ifu_rdata_q <= ifu_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
`ifdef YSYX_23060332_ARB_RR_EN
            last_lsu_q  <= last_lsu_d;
`endif
        end
    end

    assign bus.ifu_req_ready  = ifu_ready_s;
    assign bus.lsu_req_ready  = lsu_ready_s;
    assign bus.ifu_resp_valid = (state_q == ST_RESP) & ~owner_lsu_q;
    assign bus.lsu_resp_valid = (state_q == ST_RESP) & owner_lsu_q;
    assign bus.ifu_resp_rdata = ifu_rdata_q;
    assign bus.lsu_resp_rdata = lsu_rdata_q;
    assign bus.mem_ren        = mem_ren_s;
    assign bus.mem_raddr      = mem_addr_s;
    assign bus.mem_wen        = mem_wen_s;
    assign bus.mem_waddr      = mem_addr_s;
    assign bus.mem_wdata      = mem_wdata_s;
    assign bus.mem_wmask      = mem_wmask_s;

endmodule

// File: tb/tb_ysyx_23060332_mem_arbiter.sv
// Bench for ysyx_23060332_mem_arbiter: a LATENCY=1 instance for exact-cycle fetch timing and a
// LATENCY=3 instance driven through a response scoreboard against a bench-side memory model.
module tb_ysyx_23060332_mem_arbiter;

    localparam int unsigned LAT = 3;

    typedef struct {
        bit          lsu;
        logic [31:0] data;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_init = 1'b1;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          wen_cnt = 0;
    int          wen_cyc = 0;
    int          acc_c = -100;
    int          ifu_acc = 0;
    int          lsu_acc = 0;
    exp_t        sb[$];
    bit          grant_log[$];
    logic [31:0] mem3 [0:63];

    ysyx_23060332_mem_arbiter_if bus1();
    ysyx_23060332_mem_arbiter_if bus3();

    ysyx_23060332_mem_arbiter #(.LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    ysyx_23060332_mem_arbiter #(.LATENCY(LAT)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Memory model for the LATENCY=3 instance: byte-masked write on posedge, combinational read.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem3[i] <= 32'h0000_0000;
            mem3[0] <= 32'h0000_0413;
            mem3[1] <= 32'h1122_3344;
            mem3[2] <= 32'h5566_7788;
        end else if (bus3.mem_wen) begin
            for (int b = 0; b < 4; b++) begin
                if (bus3.mem_wmask[b]) mem3[bus3.mem_waddr[7:2]][8*b +: 8] <= bus3.mem_wdata[8*b +: 8];
            end
        end
    end
    assign bus3.mem_rdata = bus3.mem_ren ? mem3[bus3.mem_raddr[7:2]] : 32'h0000_0000;
    assign bus1.mem_rdata = (bus1.mem_ren && bus1.mem_raddr == 32'h8000_0000) ? 32'h0000_0413 : 32'h0000_0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor, ready-while-busy check and store-pulse recorder for the LATENCY=3 instance.
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus3.mem_wen) begin
                wen_cnt++;
                wen_cyc = cyc;
            end
            if (rst) acc_c = -100;
            if (cyc > acc_c && cyc <= acc_c + int'(LAT) + 1)
                chk("ready_busy", {30'h0, bus3.lsu_req_ready, bus3.ifu_req_ready}, 32'h0);
            if ((bus3.ifu_req_valid && bus3.ifu_req_ready) || (bus3.lsu_req_valid && bus3.lsu_req_ready))
                acc_c = cyc;
            if (bus3.ifu_resp_valid || bus3.lsu_resp_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_resp: got ifu=%b lsu=%b expected no response",
                             bus3.ifu_resp_valid, bus3.lsu_resp_valid);
                end else begin
                    e = sb.pop_front();
                    chk("resp_who", {30'h0, bus3.lsu_resp_valid, bus3.ifu_resp_valid}, e.lsu ? 32'h2 : 32'h1);
                    chk("resp_data", e.lsu ? bus3.lsu_resp_rdata : bus3.ifu_resp_rdata, e.data);
                    chk("resp_latency", 32'(cyc - e.acc), 32'(LAT + 1));
                end
            end
        end
    end

    task automatic ifu_req(input logic [31:0] a, input logic [31:0] exp_d);
        int   n = 0;
        exp_t e;
        bus3.ifu_req_valid = 1'b1;
        bus3.ifu_req_addr  = a;
        do begin
            @(negedge clk);
            n++;
        end while (!bus3.ifu_req_ready && n < 60);
        if (!bus3.ifu_req_ready) begin
            total++;
            bad++;
            $display("FAIL ifu_accept_timeout: got ready=0 expected ready=1");
        end else begin
            e.lsu = 1'b0; e.data = exp_d; e.acc = cyc;
            sb.push_back(e);
            grant_log.push_back(1'b0);
            ifu_acc = cyc;
        end
        @(posedge clk); #1;
        bus3.ifu_req_valid = 1'b0;
    endtask

    task automatic lsu_req(input logic [31:0] a, input logic w, input logic [31:0] wd,
                           input logic [7:0] wm, input logic [31:0] exp_d);
        int   n = 0;
        exp_t e;
        bus3.lsu_req_valid = 1'b1;
        bus3.lsu_req_addr  = a;
        bus3.lsu_req_wen   = w;
        bus3.lsu_req_wdata = wd;
        bus3.lsu_req_wmask = wm;
        do begin
            @(negedge clk);
            n++;
        end while (!bus3.lsu_req_ready && n < 60);
        if (!bus3.lsu_req_ready) begin
            total++;
            bad++;
            $display("FAIL lsu_accept_timeout: got ready=0 expected ready=1");
        end else begin
            e.lsu = 1'b1; e.data = exp_d; e.acc = cyc;
            sb.push_back(e);
            grant_log.push_back(1'b1);
            lsu_acc = cyc;
        end
        @(posedge clk); #1;
        bus3.lsu_req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int wen_save;
        bit exp_order [3];
        bus1.ifu_req_valid = 1'b0; bus1.ifu_req_addr = 32'h0;
        bus1.lsu_req_valid = 1'b0; bus1.lsu_req_addr = 32'h0; bus1.lsu_req_wen = 1'b0;
        bus1.lsu_req_wdata = 32'h0; bus1.lsu_req_wmask = 8'h00;
        bus3.ifu_req_valid = 1'b0; bus3.ifu_req_addr = 32'h0;
        bus3.lsu_req_valid = 1'b0; bus3.lsu_req_addr = 32'h0; bus3.lsu_req_wen = 1'b0;
        bus3.lsu_req_wdata = 32'h0; bus3.lsu_req_wmask = 8'h00;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl3", {26'h0, bus3.ifu_req_ready, bus3.lsu_req_ready, bus3.ifu_resp_valid,
                            bus3.lsu_resp_valid, bus3.mem_ren, bus3.mem_wen}, 32'h0);
        chk("reset_rdata3", bus3.ifu_resp_rdata | bus3.lsu_resp_rdata | bus3.mem_raddr, 32'h0);
        chk("reset_ctrl1", {30'h0, bus1.ifu_resp_valid, bus1.mem_ren}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        mem_init = 1'b0;

        // LATENCY=1 fetch, cycle by cycle.
        bus1.ifu_req_valid = 1'b1;
        bus1.ifu_req_addr  = 32'h8000_0000;
        @(negedge clk);
        chk("l1_c0_ready", {31'h0, bus1.ifu_req_ready}, 32'h1);
        chk("l1_c0_ren", {31'h0, bus1.mem_ren}, 32'h0);
        @(posedge clk); #1;
        bus1.ifu_req_valid = 1'b0;
        @(negedge clk);
        chk("l1_c1_ren", {31'h0, bus1.mem_ren}, 32'h1);
        chk("l1_c1_raddr", bus1.mem_raddr, 32'h8000_0000);
        chk("l1_c1_resp", {30'h0, bus1.ifu_resp_valid, bus1.ifu_req_ready}, 32'h0);
        @(negedge clk);
        chk("l1_c2_resp", {30'h0, bus1.lsu_resp_valid, bus1.ifu_resp_valid}, 32'h1);
        chk("l1_c2_rdata", bus1.ifu_resp_rdata, 32'h0000_0413);
        @(negedge clk);
        chk("l1_c3_resp", {30'h0, bus1.lsu_resp_valid, bus1.ifu_resp_valid}, 32'h0);
        chk("l1_c3_hold", bus1.ifu_resp_rdata, 32'h0000_0413);
        @(posedge clk); #1;

        // LATENCY=3 store, then read it back.
        wen_save = wen_cnt;
        lsu_req(32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 8'h0F, 32'h0);
        wait_drain();
        chk("store_wen_cycle", 32'(wen_cyc - lsu_acc), 32'd3);
        chk("store_wen_count", 32'(wen_cnt - wen_save), 32'd1);
        lsu_req(32'h8000_0010, 1'b0, 32'h0, 8'h00, 32'hDEAD_BEEF);
        wait_drain();

        // Empty-mask store: full handshake, no write.
        wen_save = wen_cnt;
        lsu_req(32'h8000_0004, 1'b1, 32'hCAFE_F00D, 8'h00, 32'h0);
        wait_drain();
        chk("mask0_no_wen", 32'(wen_cnt - wen_save), 32'd0);
        lsu_req(32'h8000_0004, 1'b0, 32'h0, 8'h00, 32'h1122_3344);
        wait_drain();

        // Partial-mask store to bytes 0 and 2.
        lsu_req(32'h8000_0008, 1'b1, 32'hAABB_CCDD, 8'h05, 32'h0);
        wait_drain();
        lsu_req(32'h8000_0008, 1'b0, 32'h0, 8'h00, 32'h55BB_77DD);
        wait_drain();

        // Conflict: IFU wants two fetches, LSU one load, all presented together.
        grant_log.delete();
        fork
            begin
                ifu_req(32'h8000_0000, 32'h0000_0413);
                ifu_req(32'h8000_0004, 32'h1122_3344);
            end
            lsu_req(32'h8000_0008, 1'b0, 32'h0, 8'h00, 32'h55BB_77DD);
        join
        wait_drain();
`ifdef YSYX_23060332_ARB_RR_EN
        exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0;
`else
        exp_order[0] = 1'b1; exp_order[1] = 1'b0; exp_order[2] = 1'b0;
`endif
        chk("grant_count", 32'(grant_log.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < grant_log.size()) chk("grant_order", {31'h0, grant_log[i]}, {31'h0, exp_order[i]});
        end

        // IFU raises valid while the LSU load is in ACCESS and holds it until served.
        fork
            lsu_req(32'h8000_0010, 1'b0, 32'h0, 8'h00, 32'hDEAD_BEEF);
            begin
                @(posedge clk); #1;
                ifu_req(32'h8000_0008, 32'h55BB_77DD);
            end
        join
        wait_drain();
        chk("b2b_spacing", 32'(ifu_acc - lsu_acc), 32'(LAT + 2));

        // Reset during the second ACCESS cycle of a store.
        wen_save = wen_cnt;
        bus3.lsu_req_valid = 1'b1;
        bus3.lsu_req_addr  = 32'h8000_0014;
        bus3.lsu_req_wen   = 1'b1;
        bus3.lsu_req_wdata = 32'h1234_5678;
        bus3.lsu_req_wmask = 8'h0F;
        @(negedge clk);
        chk("rst_store_ready", {31'h0, bus3.lsu_req_ready}, 32'h1);
        @(posedge clk); #1;
        bus3.lsu_req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_cycle_wen", {31'h0, bus3.mem_wen}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus3.ifu_req_valid = 1'b1;
        bus3.ifu_req_addr  = 32'h8000_0000;
        bus3.lsu_req_valid = 1'b1;
        bus3.lsu_req_wen   = 1'b0;
        @(negedge clk);
`ifdef YSYX_23060332_ARB_RR_EN
        chk("rst_fresh_arb", {30'h0, bus3.lsu_req_ready, bus3.ifu_req_ready}, 32'h1);
`else
        chk("rst_fresh_arb", {30'h0, bus3.lsu_req_ready, bus3.ifu_req_ready}, 32'h2);
`endif
        chk("rst_after_ctrl", {29'h0, bus3.ifu_resp_valid, bus3.lsu_resp_valid, bus3.mem_wen}, 32'h0);
        bus3.ifu_req_valid = 1'b0;
        bus3.lsu_req_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_no_wen", 32'(wen_cnt - wen_save), 32'd0);
        lsu_req(32'h8000_0014, 1'b0, 32'h0, 8'h00, 32'h0);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
